ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter: serialises one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) from the FPGA to the keyboard over the same two open-drain lines used by the PS2_Control receiver. It runs on the system clock, oversamples the keyboard-generated PS/2 clock, and drives each line only by pulling it low through an output-enable. While `oBusy` is high the receiver must ignore the lines.

---
 rtl/ps2_host_tx.sv | 237 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
//
// PS/2 host-to-device transmitter. Sends one command byte to the keyboard
// over the shared open-drain PS/2 clock and data lines. Lines are only ever
// pulled low through the output-enables; releasing an enable lets the
// external pull-up take the line high.
//
// Sequence: hold clock low (inhibit), present the start bit, release the
// clock, then present the eight data bits (LSB first), the odd parity bit
// and the stop bit on successive device falling edges. The 11th falling
// edge carries the device acknowledge. The block finishes once both lines
// have returned high.
//
// Parameters:
//   INHIBIT_CYCLES  system clocks the clock line is held low before start
//   TIMEOUT_CYCLES  system clocks allowed from clock release to line idle
//
// Ports:
//   Clock       system clock, rising-edge logic
//   Reset       asynchronous active-low reset
//   iPS2CLK     PS/2 clock pin (asynchronous, synchronised here)
//   iPS2D       PS/2 data pin (asynchronous, synchronised here)
//   iData[7:0]  byte to send, captured when a request is accepted
//   iSend       request strobe, accepted only while oBusy = 0
//   oPS2CLK_OE  1 = pull PS/2 clock low
//   oPS2D_OE    1 = pull PS/2 data low
//   oBusy       transfer in progress (receiver should ignore the lines)
//   oDone       one-cycle pulse: byte sent and line returned idle
//   oError      one-cycle pulse: timeout (or rejected acknowledge)
//
// Build option:
//   PS2_TX_ACK_CHECK_EN  when defined, a high data line on the acknowledge
//                        edge is reported through oError instead of oDone.
// ----------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iPS2CLK,
    input  logic       iPS2D,
    input  logic [7:0] iData,
    input  logic       iSend,
    output logic       oPS2CLK_OE,
    output logic       oPS2D_OE,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_DATA,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic            r_clk_s1, r_clk_s2, r_clk_prev;
    logic            r_d_s1, r_d_s2;
    logic            w_fall;

    logic [9:0]      r_shift;
    logic [3:0]      r_bit;
    logic [CW-1:0]   r_cnt;
    logic            r_d_oe;
    logic            r_done;
    logic            r_error;

    logic            w_load;
    logic            w_cnt_clr;
    logic            w_start;
    logic            w_shift;
    logic            w_done_set;
    logic            w_err_set;
    logic            w_timeout;

    // Synchronisers reset to 1 (idle bus level) so no false edge appears
    // right after reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_d_s1     <= 1'b1;
            r_d_s2     <= 1'b1;
        end else begin
            r_clk_s1   <= iPS2CLK;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_d_s1     <= iPS2D;
            r_d_s2     <= r_d_s1;
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_s2;
    assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_cnt_clr    = 1'b0;
        w_start      = 1'b0;
        w_shift      = 1'b0;
        w_done_set   = 1'b0;
        w_err_set    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (iSend) begin
                    w_load       = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_state_next = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (r_cnt == CW'(INHIBIT_CYCLES - 1)) begin
                    w_start      = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_fall) begin
                    w_shift = 1'b1;
                    // The 10th edge presents the stop bit.
                    if (r_bit == 4'd9) begin
                        w_state_next = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (w_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
                    if (r_d_s2) begin
                        w_err_set    = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_WAIT_IDLE;
                    end
`else
                    w_state_next = S_WAIT_IDLE;
`endif
                end
            end
            S_WAIT_IDLE: begin
                if (r_clk_s2 && r_d_s2) begin
                    w_done_set   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Timeout overrides any completion in the same cycle so that done
        // and error can never pulse together.
        if ((r_state == S_REQ || r_state == S_DATA || r_state == S_ACK ||
             r_state == S_WAIT_IDLE) && w_timeout) begin
            w_done_set   = 1'b0;
            w_err_set    = 1'b1;
            w_shift      = 1'b0;
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_shift <= '0;
            r_bit   <= '0;
            r_cnt   <= '0;
            r_d_oe  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_done  <= w_done_set;
            r_error <= w_err_set;

            if (w_cnt_clr || r_state == S_IDLE) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_load) begin
                r_shift <= {1'b1, ~^iData, iData};
                r_bit   <= '0;
                r_d_oe  <= 1'b0;
            end

            if (w_start) begin
                r_d_oe <= 1'b1;
            end

            // Drive the inverse of the presented bit: a 0 pulls the line low.
            if (w_shift) begin
                r_d_oe  <= ~r_shift[0];
                r_shift <= {1'b1, r_shift[9:1]};
                r_bit   <= r_bit + 4'd1;
            end

            if (w_state_next == S_IDLE) begin
                r_d_oe <= 1'b0;
            end
        end
    end

    // Output enables are gated by state so the asynchronous reset releases
    // both lines without waiting for a clock edge.
    assign oPS2CLK_OE = (r_state == S_INHIBIT) || (r_state == S_REQ);
    assign oPS2D_OE   = r_d_oe && ((r_state == S_REQ) || (r_state == S_DATA));
    assign oBusy      = (r_state != S_IDLE);
    assign oDone      = r_done;
    assign oError     = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TMO = 1200;
    localparam int HP  = 25;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       send = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_d_low = 1'b0;
    logic       clk_oe, d_oe, busy, done, err;
    logic       ps2clk, ps2d;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    logic pulse_busy = 1'b0;
    logic pulse_oe = 1'b0;

    always #5 clk = ~clk;

    // Open-drain bus with pull-ups.
    assign ps2clk = ~(clk_oe | dev_clk_low);
    assign ps2d   = ~(d_oe | dev_d_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .Clock      (clk),
        .Reset      (rst_n),
        .iPS2CLK    (ps2clk),
        .iPS2D      (ps2d),
        .iData      (data),
        .iSend      (send),
        .oPS2CLK_OE (clk_oe),
        .oPS2D_OE   (d_oe),
        .oBusy      (busy),
        .oDone      (done),
        .oError     (err)
    );

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) both_cnt++;
        if (done || err) begin
            pulse_busy = busy;
            pulse_oe   = clk_oe | d_oe;
        end
    end

    // Line sequence the device should observe: start, 8 data LSB first,
    // odd parity, stop.
    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            f[k+1] = d[k];
            ones += int'(d[k]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Caller must be just after a rising edge.
    task automatic start_send(input logic [7:0] d, output logic busy_after);
        data = d;
        send = 1'b1;
        @(posedge clk); #1;
        send = 1'b0;
        busy_after = busy;
    endtask

    // Keyboard model: clocks n_falls edges, samples the data line while the
    // clock is high before each falling edge, optionally acks on edge 11.
    task automatic dev_run(input int n_falls, input bit ack_low,
                           output logic [10:0] bits, output bit ok);
        int w;
        ok = 1'b1;
        bits = '0;
        w = 0;
        while (!(clk_oe == 1'b0 && ps2clk == 1'b1) && w < 5000) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 5000) begin
            ok = 1'b0;
        end else begin
            for (int i = 0; i < n_falls; i++) begin
                repeat (HP) @(posedge clk);
                #1;
                if (i < 11) bits[i] = ps2d;
                if (i == 10 && ack_low) begin
                    dev_d_low = 1'b1;
                    repeat (5) @(posedge clk);
                    #1;
                end
                dev_clk_low = 1'b1;
                repeat (HP) @(posedge clk);
                #1;
                dev_clk_low = 1'b0;
            end
            if (ack_low) begin
                repeat (5) @(posedge clk);
                #1;
                dev_d_low = 1'b0;
            end
        end
    endtask

    task automatic run_transfer(input logic [7:0] d, input bit ack_low,
                                output logic [10:0] bits, output bit ok,
                                output logic busy_after, output bit got_pulse);
        bit dev_ok;
        int k;
        start_send(d, busy_after);
        got_pulse = 1'b0;
        fork
            dev_run(11, ack_low, bits, dev_ok);
            begin
                k = 0;
                while (!(done || err) && k < 3000) begin
                    @(posedge clk); #1;
                    k++;
                end
                got_pulse = (done || err);
            end
        join
        ok = dev_ok;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe got %b want 0", clk_oe); end
        checks++; if (d_oe !== 1'b0)   begin errors++; $display("FAIL reset_d_oe got %b want 0", d_oe); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (err !== 1'b0)    begin errors++; $display("FAIL reset_error got %b want 0", err); end
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("test_reset: outputs idle after reset");
    endtask

    task automatic test_send_ed;
        logic [10:0] bits;
        bit ok;
        logic b;
        int k, d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        start_send(8'hED, b);
        checks++; if (b !== 1'b1)      begin errors++; $display("FAIL ed_busy_n1 got %b want 1", b); end
        checks++; if (clk_oe !== 1'b1) begin errors++; $display("FAIL ed_clk_oe_n1 got %b want 1", clk_oe); end
        checks++; if (d_oe !== 1'b0)   begin errors++; $display("FAIL ed_d_oe_n1 got %b want 0", d_oe); end
        fork
            dev_run(11, 1'b1, bits, ok);
            begin
                k = 0;
                while (d_oe !== 1'b1 && k < INH + 10) begin
                    @(posedge clk); #1;
                    k++;
                end
                checks++; if (k != INH) begin errors++; $display("FAIL ed_d_oe_rise got %0d want %0d", k, INH); end
                @(posedge clk); #1;
                checks++; if (clk_oe !== 1'b0 || d_oe !== 1'b1) begin
                    errors++; $display("FAIL ed_clk_release got clk_oe=%b d_oe=%b want 0/1", clk_oe, d_oe);
                end
            end
        join
        k = 0;
        while (done_cnt == d0 && err_cnt == e0 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (!ok) begin errors++; $display("FAIL ed_dev_release got 0 want 1"); end
        checks++; if (bits !== exp_frame(8'hED)) begin errors++; $display("FAIL ed_bits got %b want %b", bits, exp_frame(8'hED)); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ed_done_count got %0d want 1", done_cnt - d0); end
        checks++; if (err_cnt != e0) begin errors++; $display("FAIL ed_error_count got %0d want 0", err_cnt - e0); end
        checks++; if (pulse_busy !== 1'b0 || pulse_oe !== 1'b0) begin
            errors++; $display("FAIL ed_pulse_idle got busy=%b oe=%b want 0/0", pulse_busy, pulse_oe);
        end
        $display("test_send_ed: data=0xED bits=%b", bits);
    endtask

    task automatic test_send_f4;
        logic [10:0] bits;
        bit ok, gp;
        logic b;
        int d0;
        d0 = done_cnt;
        run_transfer(8'hF4, 1'b1, bits, ok, b, gp);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bits !== exp_frame(8'hF4)) begin errors++; $display("FAIL f4_bits got %b want %b", bits, exp_frame(8'hF4)); end
        checks++; if (bits[9] !== 1'b0) begin errors++; $display("FAIL f4_parity got %b want 0", bits[9]); end
        checks++; if (done_cnt - d0 != 1 || !gp) begin errors++; $display("FAIL f4_done got %0d want 1", done_cnt - d0); end
        $display("test_send_f4: data=0xF4 bits=%b", bits);
    endtask

    task automatic test_timeout;
        logic b;
        int k, d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        start_send(8'hFF, b);
        k = 0;
        while (err !== 1'b1 && k < INH + TMO + 100) begin
            @(posedge clk); #1;
            k++;
        end
        checks++; if (k < INH + TMO - 2 || k > INH + TMO + 3) begin
            errors++; $display("FAIL timeout_cycle got %0d want %0d", k, INH + TMO);
        end
        checks++; if (clk_oe !== 1'b0 || d_oe !== 1'b0) begin
            errors++; $display("FAIL timeout_oe got clk_oe=%b d_oe=%b want 0/0", clk_oe, d_oe);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b want 0", busy); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL timeout_done got %0d want 0", done_cnt - d0); end
        checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL timeout_error_count got %0d want 1", err_cnt - e0); end
        $display("test_timeout: data=0xFF error after %0d cycles", k);
    endtask

    task automatic test_noack;
        logic [10:0] bits;
        bit ok, gp;
        logic b;
        int d0, e0, exp_d, exp_e;
        d0 = done_cnt; e0 = err_cnt;
`ifdef PS2_TX_ACK_CHECK_EN
        exp_d = 0; exp_e = 1;
`else
        exp_d = 1; exp_e = 0;
`endif
        run_transfer(8'h00, 1'b0, bits, ok, b, gp);
        repeat (5) @(posedge clk);
        #1;
        checks++; if (bits !== exp_frame(8'h00)) begin errors++; $display("FAIL noack_bits got %b want %b", bits, exp_frame(8'h00)); end
        checks++; if (done_cnt - d0 != exp_d) begin errors++; $display("FAIL noack_done got %0d want %0d", done_cnt - d0, exp_d); end
        checks++; if (err_cnt - e0 != exp_e) begin errors++; $display("FAIL noack_error got %0d want %0d", err_cnt - e0, exp_e); end
        $display("test_noack: data=0x00 done=%0d error=%0d", done_cnt - d0, err_cnt - e0);
    endtask

    task automatic test_reset_mid;
        logic [10:0] bits;
        bit ok, gp;
        logic b;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        start_send(8'hED, b);
        dev_run(4, 1'b0, bits, ok);
        repeat (3) @(posedge clk);
        #3;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (clk_oe !== 1'b0 || d_oe !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_async got clk_oe=%b d_oe=%b busy=%b want 0/0/0", clk_oe, d_oe, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (done_cnt != d0 || err_cnt != e0) begin
            errors++; $display("FAIL rstmid_no_pulse got done=%0d err=%0d want 0/0", done_cnt - d0, err_cnt - e0);
        end
        run_transfer(8'hED, 1'b1, bits, ok, b, gp);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bits !== exp_frame(8'hED)) begin errors++; $display("FAIL rstmid_bits got %b want %b", bits, exp_frame(8'hED)); end
        checks++; if (done_cnt - d0 != 1 || err_cnt != e0) begin
            errors++; $display("FAIL rstmid_done got done=%0d err=%0d want 1/0", done_cnt - d0, err_cnt - e0);
        end
        $display("test_reset_mid: reset mid-frame then 0xED bits=%b", bits);
    endtask

    task automatic test_ignore;
        logic [10:0] bits;
        bit ok;
        logic b;
        int k, d0;
        d0 = done_cnt;
        start_send(8'hED, b);
        fork
            dev_run(11, 1'b1, bits, ok);
            begin
                repeat (200) @(posedge clk);
                #1;
                data = 8'h55;
                send = 1'b1;
                @(posedge clk); #1;
                send = 1'b0;
            end
        join
        k = 0;
        while (done_cnt == d0 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (50) @(posedge clk);
        #1;
        checks++; if (bits !== exp_frame(8'hED)) begin errors++; $display("FAIL ignore_bits got %b want %b", bits, exp_frame(8'hED)); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ignore_done got %0d want 1", done_cnt - d0); end
        checks++; if (busy !== 1'b0 || clk_oe !== 1'b0) begin
            errors++; $display("FAIL ignore_not_queued got busy=%b clk_oe=%b want 0/0", busy, clk_oe);
        end
        $display("test_ignore: 0x55 during 0xED ignored bits=%b", bits);
    endtask

    task automatic test_back_to_back;
        logic [10:0] bits;
        logic [7:0] d;
        bit ok, gp;
        logic b;
        int d0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            d0 = done_cnt;
            // After the first pass this runs in the pulse cycle itself.
            run_transfer(d, 1'b1, bits, ok, b, gp);
            checks++; if (b !== 1'b1) begin errors++; $display("FAIL b2b_accept[%0d] got %b want 1", i, b); end
            checks++; if (bits !== exp_frame(d)) begin errors++; $display("FAIL b2b_bits[%0d] got %b want %b", i, bits, exp_frame(d)); end
            checks++; if (!gp || done !== 1'b1) begin errors++; $display("FAIL b2b_done[%0d] got %b want 1", i, done); end
            $display("test_back_to_back: data=0x%02h bits=%b", d, bits);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL done_error_overlap got %0d want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_send_f4();
        test_timeout();
        test_noack();
        test_reset_mid();
        test_ignore();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "simulation time limit");
    end

endmodule
